// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 definitions: 8b/10b control characters, receive word classes,
// framer states and the counting test pattern.
package tlk2711_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D11_5 = 8'hAB;

  typedef enum logic [1:0] {
    WComma,
    WSof,
    WData,
    WInvalid
  } word_class_e;

  typedef enum logic [1:0] {
    StUnlock,
    StHunt,
    StData
  } framer_state_e;

  // Counting pattern: payload word k carries k[4:0] in both bytes.
  function automatic logic [15:0] pat_word(input logic [4:0] k);
    return {3'b000, k, 3'b000, k};
  endfunction

endpackage

// File: rtl/tlk2711_rx_word_class.sv
// Input register stage: captures the receive bus and classifies each word.
module tlk2711_rx_word_class
  import tlk2711_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] rxd_i,
  input  logic        rkmsb_i,
  input  logic        rklsb_i,
  output word_class_e class_o,
  output logic [15:0] data_o
);

  word_class_e class_d, class_q;
  logic [15:0] data_q;

  always_comb begin
    class_d = WInvalid;
    if (!rkmsb_i && !rklsb_i) begin
      class_d = WData;
    end else if (rkmsb_i && !rklsb_i && rxd_i[15:8] == K28_5) begin
      if (rxd_i[7:0] == D5_6) begin
        class_d = WComma;
      end else if (rxd_i[7:0] == D11_5) begin
        class_d = WSof;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      class_q <= WInvalid;
      data_q  <= '0;
    end else begin
      class_q <= class_d;
      data_q  <= rxd_i;
    end
  end

  assign class_o = class_q;
  assign data_o  = data_q;

endmodule

// File: rtl/tlk2711_rx_framer.sv
// TLK2711 receive framer: comma lock, SOF delineation, payload delivery,
// counting-pattern check and saturating frame/error statistics.
module tlk2711_rx_framer
  import tlk2711_pkg::*;
#(
  parameter int unsigned FrameLen = 32,
  parameter int unsigned LockCnt  = 3,
  parameter int unsigned LossCnt  = 4,
  parameter bit          CheckEn  = 1'b1
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic [15:0] i_rxd,
  input  logic        i_rkmsb,
  input  logic        i_rklsb,
  input  logic        i_clr,
  output logic        o_sync,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_pat_err,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int unsigned LockW = (LockCnt > 1) ? $clog2(LockCnt) : 1;
  localparam int unsigned LossW = $clog2(LossCnt + 1);
  localparam logic [7:0]  LastK = 8'(FrameLen - 1);

  word_class_e cls;
  logic [15:0] wdata;

  tlk2711_rx_word_class u_word_class (
    .clk_i   (rx_clk),
    .rst_ni  (rst_n),
    .rxd_i   (i_rxd),
    .rkmsb_i (i_rkmsb),
    .rklsb_i (i_rklsb),
    .class_o (cls),
    .data_o  (wdata)
  );

  framer_state_e state_d, state_q;
  logic [LockW-1:0] lock_d, lock_q;
  logic [LossW-1:0] run_d, run_q;
  logic [7:0]       k_d, k_q;
  logic             bad_d, bad_q;
  logic             sync_d, sync_q;
  logic [15:0]      data_d, data_q;
  logic             valid_d, valid_q;
  logic             sof_d, sof_q;
  logic             eof_d, eof_q;
  logic             err_d, err_q;
  logic [15:0]      frame_cnt_d, frame_cnt_q;
  logic [15:0]      err_cnt_d, err_cnt_q;
  logic             good;
  logic             mismatch;

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    run_d    = run_q;
    k_d      = k_q;
    bad_d    = bad_q;
    data_d   = '0;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    good     = 1'b0;
    mismatch = CheckEn && (wdata != pat_word(k_q[4:0]));

    unique case (state_q)
      StUnlock: begin
        run_d = '0;
        if (cls == WComma) begin
          if (lock_q == LockW'(LockCnt - 1)) begin
            state_d = StHunt;
            lock_d  = '0;
          end else begin
            lock_d = lock_q + 1'b1;
          end
        end else begin
          lock_d = '0;
        end
      end
      StHunt: begin
        unique case (cls)
          WComma: run_d = '0;
          WSof: begin
            state_d = StData;
            k_d     = '0;
            bad_d   = 1'b0;
            run_d   = '0;
          end
          WData: run_d = run_q + 1'b1;
          default: begin
            run_d = run_q + 1'b1;
            err_d = 1'b1;
          end
        endcase
      end
      StData: begin
        unique case (cls)
          WData: begin
            run_d   = '0;
            valid_d = 1'b1;
            data_d  = wdata;
            sof_d   = (k_q == '0);
            eof_d   = (k_q == LastK);
            err_d   = mismatch;
            bad_d   = bad_q | mismatch;
            k_d     = k_q + 1'b1;
            if (k_q == LastK) begin
              state_d = StHunt;
              good    = !bad_q && !mismatch;
            end
          end
          // A SOF inside a frame abandons it and starts a fresh one.
          WSof: begin
            err_d = 1'b1;
            run_d = '0;
            k_d   = '0;
            bad_d = 1'b0;
          end
          WComma: begin
            err_d   = 1'b1;
            run_d   = '0;
            state_d = StHunt;
          end
          default: begin
            err_d = 1'b1;
            bad_d = 1'b1;
            run_d = run_q + 1'b1;
          end
        endcase
      end
      default: state_d = StUnlock;
    endcase

    if (state_q != StUnlock && run_d == LossW'(LossCnt)) begin
      state_d = StUnlock;
      run_d   = '0;
      lock_d  = '0;
    end

    sync_d = (state_d != StUnlock);

    // Clear takes priority over a coincident increment.
    frame_cnt_d = frame_cnt_q;
    if (i_clr) begin
      frame_cnt_d = '0;
    end else if (good && frame_cnt_q != 16'hFFFF) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    err_cnt_d = err_cnt_q;
    if (i_clr) begin
      err_cnt_d = '0;
    end else if (err_d && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StUnlock;
      lock_q      <= '0;
      run_q       <= '0;
      k_q         <= '0;
      bad_q       <= 1'b0;
      sync_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      run_q       <= run_d;
      k_q         <= k_d;
      bad_q       <= bad_d;
      sync_q      <= sync_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_sync      = sync_q;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_eof       = eof_q;
  assign o_pat_err   = err_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tlk2711_rx_framer.sv
// Directed bench for tlk2711_rx_framer: lock, frames, pattern errors, short
// frames, lock loss, counter saturation/clear and mid-frame reset.
module tb_tlk2711_rx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rxd;
  logic        rkmsb;
  logic        rklsb;
  logic        clr;
  logic        o_sync;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_sof;
  logic        o_eof;
  logic        o_pat_err;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_err_cnt;

  always #5 clk = ~clk;

  tlk2711_rx_framer dut (
    .rx_clk      (clk),
    .rst_n       (rst_n),
    .i_rxd       (rxd),
    .i_rkmsb     (rkmsb),
    .i_rklsb     (rklsb),
    .i_clr       (clr),
    .o_sync      (o_sync),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_sof       (o_sof),
    .o_eof       (o_eof),
    .o_pat_err   (o_pat_err),
    .o_frame_cnt (o_frame_cnt),
    .o_err_cnt   (o_err_cnt)
  );

  // Output monitor: cumulative event counts plus every delivered word.
  int unsigned n_valid = 0;
  int unsigned n_sof   = 0;
  int unsigned n_eof   = 0;
  int unsigned n_perr  = 0;
  logic [15:0] vdata[$];
  logic [15:0] sof_word = '0;
  logic [15:0] eof_word = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        n_valid <= n_valid + 1;
        vdata.push_back(o_data);
        if (o_sof) begin
          n_sof    <= n_sof + 1;
          sof_word <= o_data;
        end
        if (o_eof) begin
          n_eof    <= n_eof + 1;
          eof_word <= o_data;
        end
      end
      if (o_pat_err) n_perr <= n_perr + 1;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic km, input logic kl);
    @(negedge clk);
    rxd   = d;
    rkmsb = km;
    rklsb = kl;
  endtask

  task automatic comma();
    drive(16'hBCC5, 1'b1, 1'b0);
  endtask

  task automatic sof();
    drive(16'hBCAB, 1'b1, 1'b0);
  endtask

  task automatic dat(input logic [15:0] d);
    drive(d, 1'b0, 1'b0);
  endtask

  task automatic inval();
    drive(16'h0000, 1'b0, 1'b1);
  endtask

  // Payload k = {3'b0,k[4:0],3'b0,k[4:0]}; bad_idx gets its LSB flipped.
  task automatic payload(input int n, input int bad_idx);
    logic [4:0]  kk;
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      kk = 5'(i);
      w  = {3'b000, kk, 3'b000, kk};
      if (i == bad_idx) w = w ^ 16'h0001;
      dat(w);
    end
  endtask

  task automatic flush();
    repeat (3) comma();
    #1;
  endtask

  int unsigned b_valid, b_sof, b_eof, b_perr, b_idx;

  task automatic snap();
    b_valid = n_valid;
    b_sof   = n_sof;
    b_eof   = n_eof;
    b_perr  = n_perr;
    b_idx   = vdata.size();
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = '0;
    rkmsb = 1'b0;
    rklsb = 1'b0;
    clr   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sync", 32'(o_sync), 32'd0);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    check_eq("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    rst_n = 1'b1;

    // Lock: o_sync follows the 3rd comma by two cycles.
    comma();
    comma();
    comma();
    comma();
    check_eq("sync_after_2_commas", 32'(o_sync), 32'd0);
    comma();
    check_eq("sync_after_3_commas", 32'(o_sync), 32'd1);
    flush();
    check_eq("idle_no_valid", n_valid, 32'd0);
    check_eq("idle_no_err", 32'(o_err_cnt), 32'd0);

    // Good frame.
    snap();
    sof();
    payload(32, -1);
    flush();
    check_eq("good_valid_cnt", n_valid - b_valid, 32'd32);
    check_eq("good_sof_cnt", n_sof - b_sof, 32'd1);
    check_eq("good_eof_cnt", n_eof - b_eof, 32'd1);
    check_eq("good_sof_word", 32'(sof_word), 32'h0000);
    check_eq("good_eof_word", 32'(eof_word), 32'h1F1F);
    check_eq("good_word5", 32'(vdata[b_idx + 5]), 32'h0505);
    check_eq("good_frame_cnt", 32'(o_frame_cnt), 32'd1);
    check_eq("good_err_cnt", 32'(o_err_cnt), 32'd0);

    // Word 5 corrupted to 0x0504.
    snap();
    sof();
    payload(32, 5);
    flush();
    check_eq("corrupt_perr", n_perr - b_perr, 32'd1);
    check_eq("corrupt_err_cnt", 32'(o_err_cnt), 32'd1);
    check_eq("corrupt_frame_cnt", 32'(o_frame_cnt), 32'd1);
    check_eq("corrupt_eof", n_eof - b_eof, 32'd1);
    check_eq("corrupt_word5", 32'(vdata[b_idx + 5]), 32'h0504);

    // Short frame of 10 words, restarted by SOF, then a full frame.
    snap();
    sof();
    payload(10, -1);
    sof();
    payload(32, -1);
    flush();
    check_eq("short_err_cnt", 32'(o_err_cnt), 32'd2);
    check_eq("short_frame_cnt", 32'(o_frame_cnt), 32'd2);
    check_eq("short_valid_cnt", n_valid - b_valid, 32'd42);
    check_eq("short_sof_cnt", n_sof - b_sof, 32'd2);
    check_eq("short_eof_cnt", n_eof - b_eof, 32'd1);

    // Lock loss on 4 invalid words, then relock on 3 commas.
    snap();
    repeat (4) inval();
    comma();
    check_eq("loss_sync_held", 32'(o_sync), 32'd1);
    comma();
    check_eq("loss_sync_drop", 32'(o_sync), 32'd0);
    check_eq("loss_err_cnt", 32'(o_err_cnt), 32'd6);
    comma();
    comma();
    check_eq("relock_not_yet", 32'(o_sync), 32'd0);
    comma();
    check_eq("relock_sync", 32'(o_sync), 32'd1);
    #1;
    check_eq("loss_perr", n_perr - b_perr, 32'd4);

    // Clear, then saturate the error counter with repeated SOFs in DATA.
    @(negedge clk);
    clr = 1'b1;
    rxd = 16'hBCC5;
    @(negedge clk);
    clr = 1'b0;
    check_eq("clr_err_cnt", 32'(o_err_cnt), 32'd0);
    check_eq("clr_frame_cnt", 32'(o_frame_cnt), 32'd0);
    repeat (65537) sof();
    check_eq("sat_below", 32'(o_err_cnt), 32'hFFFE);
    sof();
    check_eq("sat_reach", 32'(o_err_cnt), 32'hFFFF);
    sof();
    check_eq("sat_hold", 32'(o_err_cnt), 32'hFFFF);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_eq("clr_wins", 32'(o_err_cnt), 32'd0);
    @(negedge clk);
    check_eq("count_after_clr", 32'(o_err_cnt), 32'd1);

    // Reset mid-frame.
    sof();
    payload(4, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(o_valid), 32'd0);
    check_eq("midrst_eof", 32'(o_eof), 32'd0);
    check_eq("midrst_sync", 32'(o_sync), 32'd0);
    check_eq("midrst_err_cnt", 32'(o_err_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
